// File: rtl/icache_nway_if.sv
// icache_nway_if: fetch request/response, set invalidate and bus read channel of the instruction cache.
interface icache_nway_if #(
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 8,
  parameter int LINE_WORDS = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W-1:0]       req_vaddr;
  logic [ADDR_W-1:0]       req_paddr;
  logic                    req_uncached;
  logic                    resp_valid;
  logic [31:0]             resp_data;
  logic                    resp_ready;
  logic                    inv_valid;
  logic [IDX_W-1:0]        inv_index;
  logic                    inv_ack;
  logic                    mem_rd_req;
  logic [ADDR_W-1:0]       mem_rd_addr;
  logic                    mem_rd_uncached;
  logic                    mem_rd_addr_ok;
  logic                    mem_rd_valid;
  logic [32*LINE_WORDS-1:0] mem_rd_data;
  logic                    hit_pulse;
  logic                    miss_pulse;
  modport slave (
    input  req_valid, req_vaddr, req_paddr, req_uncached, resp_ready, inv_valid, inv_index,
           mem_rd_addr_ok, mem_rd_valid, mem_rd_data,
    output req_ready, resp_valid, resp_data, inv_ack, mem_rd_req, mem_rd_addr, mem_rd_uncached,
           hit_pulse, miss_pulse
  );
  modport master (
    output req_valid, req_vaddr, req_paddr, req_uncached, resp_ready, inv_valid, inv_index,
           mem_rd_addr_ok, mem_rd_valid, mem_rd_data,
    input  req_ready, resp_valid, resp_data, inv_ack, mem_rd_req, mem_rd_addr, mem_rd_uncached,
           hit_pulse, miss_pulse
  );
endinterface

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative read-only instruction cache, VIPT, with uncached
// single-word reads and per-set invalidate.
module icache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input logic         clk,
  input logic         rst_n,
  icache_nway_if.slave cif
);
  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WI_W  = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int LW    = 32 * LINE_WORDS;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP, INVAL} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, inv_idx_q;
  logic [WI_W-1:0] off_q;
  logic [ADDR_W-1:2] paddr_q;
  logic unc_q, unc_ent_q;
  logic [WAY_W-1:0] victim_q, victim;
  logic [31:0] resp_data_q, hit_word;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAY_W-1:0] rr_q [SETS];
  logic [TAG_W-1:0] tag_mem [WAYS][SETS];
  logic [LW-1:0] data_mem [WAYS][SETS];
  logic [TAG_W-1:0] rd_tag_q [WAYS];
  logic [LW-1:0] rd_line_q [WAYS];
  logic hit, accept, fill, req_ready, resp_valid, inv_ack, mem_rd_req, hit_pulse, miss_pulse;
  logic [TAG_W-1:0] ptag;
  assign accept = state_q == IDLE && !cif.inv_valid && cif.req_valid;
  assign fill   = state_q == MISS_WAIT && cif.mem_rd_valid && !unc_q;
  assign ptag   = paddr_q[ADDR_W-1:IDX_W+OFF_W];
  always_comb begin
    hit = 1'b0;
    hit_word = '0;
    victim = rr_q[idx_q];
    for (int w = 0; w < WAYS; w++)
      if (valid_q[idx_q][w] && rd_tag_q[w] == ptag) begin
        hit = 1'b1;
        hit_word = rd_line_q[w][32*off_q +: 32];
      end
    // Descending scan so the lowest-numbered invalid way wins over the pointer.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[idx_q][w]) victim = WAY_W'(w);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    inv_ack = 1'b0;
    mem_rd_req = 1'b0;
    hit_pulse = 1'b0;
    miss_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !cif.inv_valid;
        state_d = cif.inv_valid ? INVAL : !cif.req_valid ? IDLE : cif.req_uncached ? MISS_REQ : LOOKUP;
      end
      LOOKUP: begin
        hit_pulse = hit;
        miss_pulse = !hit;
        state_d = hit ? RESP : MISS_REQ;
      end
      MISS_REQ: begin
        mem_rd_req = 1'b1;
        miss_pulse = unc_ent_q;
        state_d = cif.mem_rd_addr_ok ? MISS_WAIT : MISS_REQ;
      end
      MISS_WAIT: state_d = cif.mem_rd_valid ? RESP : MISS_WAIT;
      RESP: begin
        resp_valid = 1'b1;
        state_d = cif.resp_ready ? IDLE : RESP;
      end
      INVAL: begin
        inv_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q <= '0;
      inv_idx_q <= '0;
      off_q <= '0;
      paddr_q <= '0;
      unc_q <= 1'b0;
      unc_ent_q <= 1'b0;
      victim_q <= '0;
      resp_data_q <= '0;
      valid_q <= '{default: '0};
      rr_q <= '{default: '0};
    end else begin
      if (accept) begin
        idx_q <= cif.req_vaddr[OFF_W +: IDX_W];
        off_q <= WI_W'(cif.req_vaddr[OFF_W-1:0] >> 2);
        paddr_q <= cif.req_paddr[ADDR_W-1:2];
        unc_q <= cif.req_uncached;
      end
      unc_ent_q <= accept && cif.req_uncached;
      if (state_q == IDLE && cif.inv_valid) inv_idx_q <= cif.inv_index;
      if (state_q == INVAL) valid_q[inv_idx_q] <= '0;
      if (state_q == LOOKUP) victim_q <= victim;
      if (state_q == LOOKUP && hit) resp_data_q <= hit_word;
      if (state_q == MISS_WAIT && cif.mem_rd_valid)
        resp_data_q <= unc_q ? cif.mem_rd_data[31:0] : cif.mem_rd_data[32*off_q +: 32];
      if (fill) begin
        valid_q[idx_q][victim_q] <= 1'b1;
        rr_q[idx_q] <= rr_q[idx_q] == WAY_W'(WAYS - 1) ? '0 : rr_q[idx_q] + 1'b1;
      end
    end
  // Tag/data arrays: no reset, read for all ways at acceptance, written on a cached fill.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++)
      if (accept) begin
        rd_tag_q[w] <= tag_mem[w][cif.req_vaddr[OFF_W +: IDX_W]];
        rd_line_q[w] <= data_mem[w][cif.req_vaddr[OFF_W +: IDX_W]];
      end
    if (fill) begin
      tag_mem[victim_q][idx_q] <= ptag;
      data_mem[victim_q][idx_q] <= cif.mem_rd_data;
    end
  end
  assign cif.req_ready = req_ready;
  assign cif.resp_valid = resp_valid;
  assign cif.resp_data = resp_data_q;
  assign cif.inv_ack = inv_ack;
  assign cif.mem_rd_req = mem_rd_req;
  assign cif.mem_rd_uncached = state_q == MISS_REQ && unc_q;
  assign cif.mem_rd_addr = state_q != MISS_REQ ? '0 :
                           unc_q ? {paddr_q, 2'b00} : {paddr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign cif.hit_pulse = hit_pulse;
  assign cif.miss_pulse = miss_pulse;
endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: randomized and directed fetches against a line-level cache model, checked by a scoreboard.
module tb_icache_nway;
  localparam int WAYS = 2, SETS = 256, LW = 8;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  icache_nway_if #(.ADDR_W(32), .IDX_W(8), .LINE_WORDS(LW)) cif ();
  icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cif(cif.slave));
  typedef struct {logic [31:0] data; bit hit; int acc;} exp_t;
  exp_t exp_q[$];
  bit pulse_q[$];
  logic [32:0] mem_q[$];
  int tests = 0, fails = 0, inv_pend = 0, cyc = 0;
  bit m_valid [SETS][WAYS];
  logic [31:0] m_line [SETS][WAYS];
  int m_rr [SETS];
  int b_st = 0, b_cnt = 0;
  bit b_hold = 0;
  logic [31:0] b_addr;
  bit b_unc;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] la, input int i);
    return la == 32'h1C00_0000 ? 32'hA0 + i : la ^ 32'h5A5A_0000 ^ (i * 32'h0101_0101);
  endfunction
  function automatic logic [31:0] uword(input logic [31:0] a);
    return a == 32'h1FD0_0004 ? 32'hDEAD_BEEF : ~a;
  endfunction
  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
    end
  endtask
  task automatic model_inval(input int s);
    for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
  endtask
  // A line is found by comparing the stored physical line's tag; the set comes from the virtual address.
  task automatic model_req(input logic [31:0] va, input logic [31:0] pa, input bit unc);
    exp_t e;
    int s, off, v;
    logic [31:0] la;
    e.acc = cyc;
    e.hit = 0;
    if (unc) begin
      pulse_q.push_back(0);
      mem_q.push_back({pa & ~32'h3, 1'b1});
      e.data = uword(pa & ~32'h3);
    end else begin
      s = int'(va[12:5]);
      off = int'(va[4:2]);
      la = pa & ~32'h1F;
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_line[s][w][31:13] == pa[31:13]) begin
          e.hit = 1;
          e.data = mem_word(m_line[s][w], off);
        end
      if (!e.hit) begin
        v = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
        m_valid[s][v] = 1;
        m_line[s][v] = la;
        mem_q.push_back({la, 1'b0});
        e.data = mem_word(la, off);
      end
      pulse_q.push_back(e.hit);
    end
    exp_q.push_back(e);
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (cif.req_ready) return;
    end
    chk("idle_timeout", 1, 0);
  endtask
  task automatic issue(input logic [31:0] va, input logic [31:0] pa, input bit unc, input bit wi,
                       input logic [7:0] ii);
    @(negedge clk);
    cif.req_valid = 1;
    cif.req_vaddr = va;
    cif.req_paddr = pa;
    cif.req_uncached = unc;
    if (wi) begin
      cif.inv_valid = 1;
      cif.inv_index = ii;
      inv_pend++;
      model_inval(int'(ii));
    end
    for (int n = 0; ; n++) begin
      #1;
      if (wi && n == 0) chk("inv_priority_ready", cif.req_ready, 0);
      if (cif.req_ready) break;
      if (n > 400) begin
        chk("accept_timeout", 1, 0);
        cif.req_valid = 0;
        cif.inv_valid = 0;
        return;
      end
      @(negedge clk);
      cif.inv_valid = 0;
    end
    model_req(va, pa, unc);
    @(posedge clk);
    #1;
    cif.req_valid = 0;
    cif.inv_valid = 0;
  endtask
  task automatic inval(input logic [7:0] ii);
    wait_idle();
    cif.inv_valid = 1;
    cif.inv_index = ii;
    inv_pend++;
    model_inval(int'(ii));
    @(negedge clk);
    cif.inv_valid = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("reset_flags", {cif.req_ready, cif.resp_valid, cif.inv_ack, cif.mem_rd_req,
                        cif.mem_rd_uncached, cif.hit_pulse, cif.miss_pulse}, 7'b1000000);
    chk("reset_addr_data", {cif.mem_rd_addr, cif.resp_data}, 64'h0);
    exp_q.delete();
    pulse_q.delete();
    mem_q.delete();
    inv_pend = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  // Bus responder: random address-accept delay, data sometimes in the same cycle as addr_ok.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      b_st = 0;
      cif.mem_rd_addr_ok = 0;
      cif.mem_rd_valid = 0;
    end else case (b_st)
      0: begin
        cif.mem_rd_addr_ok = 0;
        cif.mem_rd_valid = 0;
        if (cif.mem_rd_req) begin
          b_addr = cif.mem_rd_addr;
          b_unc = cif.mem_rd_uncached;
          b_cnt = $urandom_range(0, 2);
          b_st = 1;
        end
      end
      1: if (b_cnt > 0) b_cnt--;
         else begin
           for (int i = 0; i < LW; i++)
             cif.mem_rd_data[32*i +: 32] = b_unc ? (i == 0 ? uword(b_addr) : 32'hBAD0_0000 | i)
                                                 : mem_word(b_addr, i);
           cif.mem_rd_addr_ok = 1;
           cif.mem_rd_valid = ($urandom_range(0, 1) == 1) && !b_hold;
           b_cnt = cif.mem_rd_valid ? 0 : $urandom_range(0, 2);
           b_st = 2;
         end
      2: begin
        cif.mem_rd_addr_ok = 0;
        if (b_hold) cif.mem_rd_valid = 0;
        else if (b_cnt == 0) begin
          cif.mem_rd_valid = 1;
          b_st = 3;
        end else begin
          cif.mem_rd_valid = 0;
          b_cnt--;
        end
      end
      default: begin
        cif.mem_rd_valid = 0;
        b_st = 0;
      end
    endcase
  end
  // Monitor: compares every response, perf pulse, bus request and invalidate ack with the queues.
  initial begin
    bit in_resp = 0, req_seen = 0, p;
    logic [31:0] held;
    exp_t e;
    logic [32:0] m;
    cif.resp_ready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_resp = 0;
        req_seen = 0;
        continue;
      end
      if (cif.hit_pulse || cif.miss_pulse) begin
        if (pulse_q.size() == 0) chk("pulse_unexpected", {cif.hit_pulse, cif.miss_pulse}, 0);
        else begin
          p = pulse_q.pop_front();
          chk("pulse_kind", {cif.hit_pulse, cif.miss_pulse}, p ? 2'b10 : 2'b01);
        end
      end
      if (cif.mem_rd_req && !req_seen) begin
        if (mem_q.size() == 0) chk("mem_req_unexpected", cif.mem_rd_addr, 64'hFFFF_FFFF_FFFF);
        else begin
          m = mem_q.pop_front();
          chk("mem_req_addr_unc", {cif.mem_rd_addr, cif.mem_rd_uncached}, m);
        end
      end
      req_seen = cif.mem_rd_req;
      if (cif.inv_ack) begin
        chk("inv_ack_expected", inv_pend > 0, 1);
        if (inv_pend > 0) inv_pend--;
      end
      if (cif.resp_valid) begin
        if (!in_resp) begin
          in_resp = 1;
          held = cif.resp_data;
          if (exp_q.size() == 0) chk("resp_unexpected", cif.resp_data, 64'hFFFF_FFFF_FFFF);
          else begin
            e = exp_q[0];
            chk("resp_data", cif.resp_data, e.data);
            if (e.hit) chk("hit_latency", cyc - e.acc, 2);
          end
        end else chk("resp_held", cif.resp_data, held);
        cif.resp_ready = $urandom_range(0, 2) != 0;
        if (cif.resp_ready) begin
          in_resp = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else cif.resp_ready = $urandom_range(0, 1);
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] pa, va;
    int r;
    cif.req_valid = 0;
    cif.req_vaddr = 0;
    cif.req_paddr = 0;
    cif.req_uncached = 0;
    cif.inv_valid = 0;
    cif.inv_index = 0;
    cif.mem_rd_addr_ok = 0;
    cif.mem_rd_valid = 0;
    cif.mem_rd_data = '0;
    do_reset();
    issue(32'h1C00_0010, 32'h1C00_0010, 0, 0, 0);
    issue(32'h1C00_0010, 32'h1C00_0010, 0, 0, 0);
    for (int t = 1; t <= 3; t++) issue(32'h20 | (t << 13), 32'h20 | (t << 13), 0, 0, 0);
    issue(32'h4024, 32'h4024, 0, 0, 0);
    issue(32'h2028, 32'h2028, 0, 0, 0);
    issue(32'h1FD0_0004, 32'h1FD0_0004, 1, 0, 0);
    issue(32'h1FD0_0004, 32'h1FD0_0004, 1, 0, 0);
    wait_idle();
    issue(32'h4020, 32'h4020, 0, 1, 8'h01);
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 15);
      pa = (32'($urandom_range(1, 4)) << 13) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
      va = $urandom_range(0, 3) == 0 ? {pa[31:13], 8'($urandom_range(0, 3)), pa[4:0]} : pa;
      if (r == 0) inval(8'($urandom_range(0, 3)));
      else if (r == 1) begin
        wait_idle();
        issue(va, pa, 0, 1, 8'($urandom_range(0, 3)));
      end else issue(va, pa, $urandom_range(0, 7) == 0, 0, 0);
    end
    issue(32'h1C00_0010, 32'h1C00_0010, 0, 0, 0);
    wait_idle();
    b_hold = 1;
    issue(32'h7FF0_0040, 32'h7FF0_0040, 0, 0, 0);
    for (int n = 0; n < 200 && b_st != 2; n++) @(negedge clk);
    chk("reached_miss_wait", b_st, 2);
    do_reset();
    b_hold = 0;
    issue(32'h1C00_0010, 32'h1C00_0010, 0, 0, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queues_drained", {exp_q.size(), pulse_q.size()}, 0);
    chk("mem_inv_drained", {mem_q.size(), inv_pend}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
